// File: rtl/shift_arbiter_if.sv
//==============================================================================
// Module      : shift_arbiter_if
// Description : Request ports A/B and result port of the shared shift unit.
//               master = requesters and result consumer, slave = arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface shift_arbiter_if #(
  parameter int N = 32
);
  logic                 a_valid;
  logic                 a_ready;
  logic [N-1:0]         a_data;
  logic [$clog2(N)-1:0] a_shamt;
  logic [1:0]           a_op;

  logic                 b_valid;
  logic                 b_ready;
  logic [N-1:0]         b_data;
  logic [$clog2(N)-1:0] b_shamt;
  logic [1:0]           b_op;

  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         out_data;
  logic                 out_id;

  modport master (
    output a_valid, a_data, a_shamt, a_op,
    input  a_ready,
    output b_valid, b_data, b_shamt, b_op,
    input  b_ready,
    input  out_valid, out_data, out_id,
    output out_ready
  );

  modport slave (
    input  a_valid, a_data, a_shamt, a_op,
    output a_ready,
    input  b_valid, b_data, b_shamt, b_op,
    output b_ready,
    output out_valid, out_data, out_id,
    input  out_ready
  );
endinterface

`default_nettype wire

// File: rtl/shift_arbiter.sv
//==============================================================================
// Module      : shift_arbiter
// Description : Round-robin arbiter sharing one 32-bit shifter (SLL/SRL/SRA)
//               between requesters A and B, with a single-entry tagged
//               result register and a consumed-result counter.
//               Optional macro SHIFT_ARBITER_ROTATE_EN: op 11 = rotate right
//               (otherwise op 11 passes the operand through).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module shift_arbiter #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  shift_arbiter_if.slave        bus,
  output logic [CNT_W-1:0]      ops_done
);

  localparam int c_SW = $clog2(N);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_out_valid;
  logic [N-1:0]       r_out_data;
  logic               r_out_id;
  logic               r_last_grant;   // 0 = A, 1 = B
  logic [CNT_W-1:0]   r_ops_done;

  logic               w_can_accept;
  logic               w_grant_a;
  logic               w_grant_b;
  logic               w_accept;
  logic [N-1:0]       w_opnd;
  logic [c_SW-1:0]    w_shamt;
  logic [1:0]         w_op;
  logic [N-1:0]       w_result;

  // Readiness is forced low while reset is held so no request is taken then.
  assign w_can_accept = rst_n & ((r_state == S_EMPTY) | bus.out_ready);

  // B wins if it is alone, or on a tie when A was served last.
  assign w_grant_b = bus.b_valid & (~bus.a_valid | ~r_last_grant);
  assign w_grant_a = bus.a_valid & ~w_grant_b;
  assign w_accept  = w_can_accept & (bus.a_valid | bus.b_valid);

  assign bus.a_ready = w_can_accept & w_grant_a;
  assign bus.b_ready = w_can_accept & w_grant_b;

  assign w_opnd  = w_grant_b ? bus.b_data  : bus.a_data;
  assign w_shamt = w_grant_b ? bus.b_shamt : bus.a_shamt;
  assign w_op    = w_grant_b ? bus.b_op    : bus.a_op;

`ifdef SHIFT_ARBITER_ROTATE_EN
  localparam logic [c_SW:0] c_NW = (c_SW + 1)'(N);
  logic [c_SW:0] w_lsh;
  logic [N-1:0]  w_rot;
  // A left shift by N (shamt = 0) yields zero, so rotate by 0 is identity.
  assign w_lsh = c_NW - {1'b0, w_shamt};
  assign w_rot = (w_opnd >> w_shamt) | (w_opnd << w_lsh);
`endif

  // Shared shift datapath for the granted requester.
  always_comb begin
    w_result = w_opnd;
    case (w_op)
      2'b00:   w_result = w_opnd << w_shamt;
      2'b01:   w_result = w_opnd >> w_shamt;
      2'b10:   w_result = $unsigned($signed(w_opnd) >>> w_shamt);
`ifdef SHIFT_ARBITER_ROTATE_EN
      default: w_result = w_rot;
`else
      default: w_result = w_opnd;
`endif
    endcase
  end

  // Output FSM: result register, grant history and consumed-result counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_id     <= 1'b0;
      r_last_grant <= 1'b1;
      r_ops_done   <= '0;
    end else begin
      if ((r_state == S_FULL) && bus.out_ready) begin
        r_ops_done <= r_ops_done + 1'b1;
      end
      if (w_accept) begin
        r_out_data   <= w_result;
        r_out_id     <= w_grant_b;
        r_last_grant <= w_grant_b;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state     <= S_FULL;
            r_out_valid <= 1'b1;
          end
        end
        S_FULL: begin
          if (bus.out_ready && !w_accept) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
  assign ops_done      = r_ops_done;

endmodule

`default_nettype wire
